// File: rtl/div_unit.sv
// Iterative signed divider for the MIPS div instruction: one restoring step per cycle,
// quotient to lo_out and remainder to hi_out, with done and divide-by-zero pulses.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StFinish} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  // Holds the remaining dividend bits on the left and collects quotient bits on the right.
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic             busy_d, done_d, div_zero_d;

  logic [WIDTH-1:0] abs_dividend, abs_divisor;
  logic [WIDTH:0]   rem_shift, rem_diff;
  logic             rem_ge;

  // Magnitudes are taken unsigned so that 0x80000000 maps to 2^31.
  assign abs_dividend = dividend[WIDTH-1] ? -dividend : dividend;
  assign abs_divisor  = divisor[WIDTH-1]  ? -divisor  : divisor;

  // Restoring step: one extra bit keeps the compare correct for a divisor of 2^31.
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, dvsr_q};
  assign rem_ge    = ~rem_diff[WIDTH];

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvsr_d     = dvsr_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    hi_d       = hi_out;
    lo_d       = lo_out;
    busy_d     = busy;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        if (start) begin
          if (divisor == '0) begin
            div_zero_d = 1'b1;
          end else begin
            state_d   = StCalc;
            busy_d    = 1'b1;
            cnt_d     = '0;
            rem_d     = '0;
            quo_d     = abs_dividend;
            dvsr_d    = abs_divisor;
            neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem_d = dividend[WIDTH-1];
          end
        end
      end
      StCalc: begin
        rem_d = rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], rem_ge};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) state_d = StFinish;
      end
      StFinish: begin
        lo_d    = neg_quo_q ? -quo_q : quo_q;
        hi_d    = neg_rem_q ? -rem_q : rem_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_out    <= '0;
      lo_out    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_out    <= hi_d;
      lo_out    <= lo_d;
      busy      <= busy_d;
      done      <= done_d;
      div_zero  <= div_zero_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed and random signed divisions against an
// arithmetic reference, plus divide-by-zero, ignored start and mid-operation reset.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dividend, divisor;
  logic [31:0] hi_out, lo_out;
  logic        busy, done, div_zero;

  int n_cmp = 0;
  int n_err = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .hi_out   (hi_out),
    .lo_out   (lo_out),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // MIPS div semantics from 64-bit signed arithmetic, truncated to 32 bits.
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = 32'(sa / sb);
    r  = 32'(sa % sb);
  endtask

  // Called #1 after a rising edge. Starts a division and watches it to completion.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit inject,
                         input string tag);
    logic [31:0] eq, er;
    int busy_n, done_n, done_at, late_busy;
    ref_div(a, b, eq, er);
    busy_n  = 0;
    done_n  = 0;
    done_at = -1;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_at < 0) done_at = i;
      end
      if (inject) begin
        if (i == 5) begin
          dividend = $urandom;
          divisor  = $urandom | 32'd1;
          start    = 1'b1;
        end
        if (i == 6)  start = 1'b0;
        if (i == 32) start = 1'b1;
        if (i == 33) start = 1'b0;
      end
      if (i > 33 && !busy) break;
      @(posedge clk); #1;
    end
    check({tag, "_done_at"}, 32'(done_at), 32'd33);
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'd34);
    check({tag, "_done_pulses"}, 32'(done_n), 32'd1);
    check({tag, "_lo"}, lo_out, eq);
    check({tag, "_hi"}, hi_out, er);
    if (inject) begin
      late_busy = 0;
      for (int i = 0; i < 5; i++) begin
        if (busy || done) late_busy++;
        @(posedge clk); #1;
      end
      check({tag, "_no_second"}, 32'(late_busy), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_hi", hi_out, 32'd0);
    check("rst_lo", lo_out, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dz", 32'(div_zero), 32'd0);

    run_div(32'd7, 32'd2, 1'b0, "p7_2");
    check("p7_2_spec_lo", lo_out, 32'd3);
    check("p7_2_spec_hi", hi_out, 32'd1);
    run_div(-32'sd7, 32'd2, 1'b0, "n7_2");
    check("n7_2_spec_lo", lo_out, 32'hFFFF_FFFD);
    check("n7_2_spec_hi", hi_out, 32'hFFFF_FFFF);
    run_div(32'd7, -32'sd2, 1'b0, "p7_n2");
    run_div(-32'sd7, -32'sd2, 1'b0, "n7_n2");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "ovf");
    check("ovf_spec_lo", lo_out, 32'h8000_0000);
    check("ovf_spec_hi", hi_out, 32'd0);
    run_div(32'h8000_0000, 32'd1, 1'b0, "min_1");
    run_div(32'd5, 32'd9, 1'b0, "p5_9");

    // Divide by zero must leave the previous results in place.
    run_div(32'd100, 32'd7, 1'b0, "pre100_7");
    dividend = 32'd3;
    divisor  = 32'd0;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("dz_pulse", 32'(div_zero), 32'd1);
    check("dz_busy", 32'(busy), 32'd0);
    check("dz_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    check("dz_pulse_end", 32'(div_zero), 32'd0);
    check("dz_no_done", 32'(done), 32'd0);
    check("dz_lo_kept", lo_out, 32'd14);
    check("dz_hi_kept", hi_out, 32'd2);

    run_div(32'd100, 32'd7, 1'b1, "inject");
    check("inject_lo", lo_out, 32'd14);
    check("inject_hi", hi_out, 32'd2);

    // Reset asserted mid-division, away from the clock edge.
    dividend = 32'd1000;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    #2 reset = 1'b1;
    #1;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_lo", lo_out, 32'd0);
    check("mrst_hi", hi_out, 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("mrst_no_done", 32'(done | busy), 32'd0);
    end
    run_div(32'd9, 32'd3, 1'b0, "post_rst");
    check("post_rst_spec_lo", lo_out, 32'd3);

    for (int n = 0; n < 20; n++) begin
      ra = $urandom;
      rb = $urandom;
      if (n % 2 == 0) rb = rb >>> $urandom_range(0, 31);
      if (n % 3 == 0) rb = -rb;
      if (rb == 32'd0) rb = 32'd1;
      run_div(ra, rb, 1'b0, $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
